// File: rtl/ha_serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands plus carry-in,
// LSB first, one bit per clock, through two cascaded half-adder stages.
//
// Handshake rule, both ports: a transfer happens on a rising clk edge where
// valid and ready are both high. in_ready is decoded from state only (no
// input-to-output path). Upstream holds in_valid with stable operands until
// it sees in_ready. out_valid/sum/cout stay stable until out_ready is seen.
module ha_serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_s1;
  logic             w_c1;
  logic             w_s;
  logic             w_c2;
  logic             w_carry_nxt;
  logic [WIDTH:0]   w_sum_ext;
  logic [WIDTH-1:0] w_sum_nxt;
  logic             w_last;

  // Per-bit datapath: half adder on a/b, then half adder with the carry.
  assign w_s1        = r_a[0] ^ r_b[0];
  assign w_c1        = r_a[0] & r_b[0];
  assign w_s         = w_s1 ^ r_carry;
  assign w_c2        = w_s1 & r_carry;
  assign w_carry_nxt = w_c1 | w_c2;

  // New sum bit enters at the MSB; the extension keeps WIDTH=1 legal.
  assign w_sum_ext = {w_s, r_sum};
  assign w_sum_nxt = w_sum_ext[WIDTH:1];
  assign w_last    = (r_cnt == LAST_BIT);

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign busy      = r_busy;
  assign dbg_state = r_state;

  // Control FSM and serial datapath registers, all reset asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_carry <= w_carry_nxt;
          r_sum   <= w_sum_nxt;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_cout      <= w_carry_nxt;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          // Result is held until downstream takes it.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
